jtframe_pocket_slot: RTL and testbench

JTFRAME_POCKET_SLOT -- requirements
Module: jtframe_pocket_slot

---
 rtl/jtframe_pocket_pkg.sv | 29 ++
 rtl/jtframe_pocket_edge.sv | 20 ++
 rtl/jtframe_pocket_slot.sv | 133 +++++++++++++
 tb/tb_jtframe_pocket_slot.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_pocket_pkg.sv
// Shared types for the Pocket video slot block: line FSM encoding and EOL command word.
package jtframe_pocket_pkg;

   localparam int unsigned RGB_W   = 24;
   localparam int unsigned SLOT_W  = 3;
   localparam int unsigned CNT_W   = 10;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_EOL    = 2'd2,
      ST_BLANK  = 2'd3
   } line_st_t;

   // End-of-line command: reserved zero bits above the scaler slot number
   typedef struct packed {
      logic [RGB_W-SLOT_W-1:0] rsv;
      logic [SLOT_W-1:0]       slot;
   } eol_cmd_t;

   function automatic logic [RGB_W-1:0] eol_word(input logic [SLOT_W-1:0] slot);
      eol_cmd_t cmd;
      cmd.rsv  = '0;
      cmd.slot = slot;
      return cmd;
   endfunction

endpackage

// File: rtl/jtframe_pocket_edge.sv
// Rising-edge detector for a sync input, sampled only on pixel enables.
module jtframe_pocket_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic cen,
   input  logic din,
   output logic rise_c
);

   logic last;

   // Remember the sync level seen on the previous enabled pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   last <= 1'b0;
      else if (cen) last <= din;
   end

   assign rise_c = din & ~last;

endmodule

// File: rtl/jtframe_pocket_slot.sv
// Pocket video formatter: registers video, inserts EOL scaler commands,
// manages the per-frame scaler slot and counts active lines.
module jtframe_pocket_slot
   import jtframe_pocket_pkg::*;
#(
   parameter int unsigned SLOTS    = 4,
   parameter int unsigned DEF_SLOT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pxl2_cen,
   input  logic [RGB_W-1:0]  vid_rgb,
   input  logic              vid_hs,
   input  logic              vid_vs,
   input  logic              vid_de,
   input  logic [SLOT_W-1:0] slot_req,
   input  logic              slot_valid,
   output logic              slot_ready,
   output logic [SLOT_W-1:0] cur_slot,
   output logic [CNT_W-1:0]  line_cnt,
   output logic [RGB_W-1:0]  pck_rgb,
   output logic              pck_de,
   output logic              pck_hs,
   output logic              pck_vs
);

   line_st_t           st, st_nxt;
   logic [RGB_W-1:0]   rgb_nxt;
   logic               de_nxt;
   logic               line_start;
   logic               hs_rise, vs_rise, vs_ev;
   logic [CNT_W-1:0]   cnt;
   logic [SLOT_W-1:0]  pend_slot;
   logic               accept, slot_ok;

   jtframe_pocket_edge u_hs (
      .clk    (clk),
      .rst_n  (rst_n),
      .cen    (pxl2_cen),
      .din    (vid_hs),
      .rise_c (hs_rise)
   );

   jtframe_pocket_edge u_vs (
      .clk    (clk),
      .rst_n  (rst_n),
      .cen    (pxl2_cen),
      .din    (vid_vs),
      .rise_c (vs_rise)
   );

   assign vs_ev   = pxl2_cen & vs_rise;
   assign accept  = slot_valid & slot_ready;
   assign slot_ok = ({1'b0, slot_req} < 4'(SLOTS));

   // Line FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        st <= ST_IDLE;
      else if (pxl2_cen) st <= st_nxt;
   end

   // Next line state and the video word for this pixel
   always_comb begin
      st_nxt     = st;
      rgb_nxt    = '0;
      de_nxt     = 1'b0;
      line_start = 1'b0;
      case (st)
         ST_IDLE:   if (vid_de)  st_nxt = ST_ACTIVE;
         ST_ACTIVE: if (!vid_de) st_nxt = ST_EOL;
         ST_EOL:                 st_nxt = ST_BLANK;
         ST_BLANK:  if (vid_de)  st_nxt = ST_ACTIVE;
         default:                st_nxt = ST_IDLE;
      endcase
      if (vs_rise) st_nxt = ST_IDLE;
      // the EOL word goes out on the first blank pixel even if vsync arrives with it
      if (st == ST_ACTIVE && !vid_de) begin
         rgb_nxt = eol_word(cur_slot);
      end else if (st_nxt == ST_ACTIVE) begin
         de_nxt  = 1'b1;
         rgb_nxt = vid_rgb;
      end
      line_start = (st != ST_ACTIVE) && (st_nxt == ST_ACTIVE);
   end

   // Video outputs, one enabled pixel of latency
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pck_rgb <= '0;
         pck_de  <= 1'b0;
         pck_hs  <= 1'b0;
         pck_vs  <= 1'b0;
      end else if (pxl2_cen) begin
         pck_rgb <= rgb_nxt;
         pck_de  <= de_nxt;
         pck_hs  <= hs_rise;
         pck_vs  <= vs_rise;
      end
   end

   // Active line counter, saturating, latched and cleared at each frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         line_cnt <= '0;
      end else if (vs_ev) begin
         line_cnt <= cnt;
         cnt      <= '0;
      end else if (pxl2_cen && line_start && cnt != CNT_W'(CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Pending slot request, committed only at the frame boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_slot   <= SLOT_W'(DEF_SLOT);
         pend_slot  <= '0;
         slot_ready <= 1'b1;
      end else begin
         if (vs_ev) begin
            if (!slot_ready) cur_slot <= pend_slot;
            slot_ready <= 1'b1;
         end
         // a request taken on the frame edge waits for the following frame
         if (accept && slot_ok) begin
            pend_slot  <= slot_req;
            slot_ready <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtframe_pocket_slot.sv
// Bench for jtframe_pocket_slot: pixel-level behavioural model plus directed scenarios.
module tb_jtframe_pocket_slot;

   localparam int unsigned SLOTS    = 4;
   localparam int unsigned DEF_SLOT = 0;

   logic        clk = 1'b0;
   logic        rst_n, pxl2_cen, vid_hs, vid_vs, vid_de, slot_valid;
   logic [23:0] vid_rgb;
   logic [2:0]  slot_req;
   logic        slot_ready, pck_de, pck_hs, pck_vs;
   logic [2:0]  cur_slot;
   logic [9:0]  line_cnt;
   logic [23:0] pck_rgb;

   int n_cmp = 0;
   int n_err = 0;

   jtframe_pocket_slot #(.SLOTS(SLOTS), .DEF_SLOT(DEF_SLOT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pxl2_cen   (pxl2_cen),
      .vid_rgb    (vid_rgb),
      .vid_hs     (vid_hs),
      .vid_vs     (vid_vs),
      .vid_de     (vid_de),
      .slot_req   (slot_req),
      .slot_valid (slot_valid),
      .slot_ready (slot_ready),
      .cur_slot   (cur_slot),
      .line_cnt   (line_cnt),
      .pck_rgb    (pck_rgb),
      .pck_de     (pck_de),
      .pck_hs     (pck_hs),
      .pck_vs     (pck_vs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Model: video decided from the de level of this and the previous pixel,
   // slot handling as a one-deep mailbox that empties at each frame start.
   logic [23:0] e_rgb;
   logic        e_de, e_hs, e_vs, e_ready;
   logic [2:0]  e_cur, m_pend;
   logic [9:0]  e_lines;
   logic        m_pend_v, p_de, p_hs, p_vs, m_vs_ev, m_take;
   int          m_cnt;

   always @(posedge clk) begin
      if (!rst_n) begin
         e_rgb = 0; e_de = 0; e_hs = 0; e_vs = 0; e_ready = 1;
         e_cur = 3'(DEF_SLOT); e_lines = 0; m_pend = 0; m_pend_v = 0;
         p_de = 0; p_hs = 0; p_vs = 0; m_cnt = 0;
      end else begin
         m_take  = slot_valid && !m_pend_v && (int'(slot_req) < int'(SLOTS));
         m_vs_ev = pxl2_cen && vid_vs && !p_vs;
         if (pxl2_cen) begin
            e_hs = vid_hs && !p_hs;
            e_vs = m_vs_ev;
            e_de = 0;
            e_rgb = 0;
            if (p_de && !vid_de) begin
               e_rgb = {21'd0, e_cur};
            end else if (vid_de && !m_vs_ev) begin
               e_de  = 1;
               e_rgb = vid_rgb;
               if (!p_de && m_cnt < 1023) m_cnt++;
            end
            if (m_vs_ev) begin
               e_lines = 10'(m_cnt);
               m_cnt   = 0;
            end
            p_de = vid_de; p_hs = vid_hs; p_vs = vid_vs;
         end
         if (m_vs_ev) begin
            if (m_pend_v) e_cur = m_pend;
            m_pend_v = 0;
         end
         if (m_take) begin
            m_pend   = slot_req;
            m_pend_v = 1;
         end
         e_ready = !m_pend_v;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rgb",   32'(pck_rgb),    32'h0);
         chk("rst_de",    32'(pck_de),     32'h0);
         chk("rst_hs",    32'(pck_hs),     32'h0);
         chk("rst_vs",    32'(pck_vs),     32'h0);
         chk("rst_slot",  32'(cur_slot),   32'(DEF_SLOT));
         chk("rst_ready", 32'(slot_ready), 32'h1);
         chk("rst_lines", 32'(line_cnt),   32'h0);
      end else begin
         chk("rgb",   32'(pck_rgb),    32'(e_rgb));
         chk("de",    32'(pck_de),     32'(e_de));
         chk("hs",    32'(pck_hs),     32'(e_hs));
         chk("vs",    32'(pck_vs),     32'(e_vs));
         chk("slot",  32'(cur_slot),   32'(e_cur));
         chk("ready", 32'(slot_ready), 32'(e_ready));
         chk("lines", 32'(line_cnt),   32'(e_lines));
      end
   end

   // One enabled pixel followed by one disabled cycle
   task automatic pix(input logic de, input logic [23:0] rgb, input logic hs, input logic vs,
                      input logic rv = 1'b0, input logic [2:0] rs = 3'd0);
      pxl2_cen = 1; vid_de = de; vid_rgb = rgb; vid_hs = hs; vid_vs = vs;
      slot_valid = rv; slot_req = rs;
      @(posedge clk); #2;
      pxl2_cen = 0; slot_valid = 0;
      @(posedge clk); #2;
   endtask

   task automatic req(input logic [2:0] s);
      slot_valid = 1; slot_req = s;
      @(posedge clk); #2;
      slot_valid = 0;
   endtask

   task automatic line(input int ndata, input int base);
      pix(0, 24'h0, 1, 0);
      pix(0, 24'h0, 0, 0);
      for (int i = 0; i < ndata; i++) pix(1, 24'(base + i * 3 + 1), 0, 0);
      pix(0, 24'h0, 0, 0);
      pix(0, 24'h0, 0, 0);
   endtask

   task automatic frame(input int nlines, input int ndata);
      for (int l = 0; l < nlines; l++) line(ndata, l * 16);
   endtask

   task automatic vs_pix(input logic rv = 1'b0, input logic [2:0] rs = 3'd0);
      pix(0, 24'h0, 0, 1, rv, rs);
   endtask

   initial begin
      rst_n = 0; pxl2_cen = 0; vid_rgb = 0; vid_hs = 0; vid_vs = 0; vid_de = 0;
      slot_valid = 0; slot_req = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("lit_rst_slot", 32'(cur_slot), 32'h0);
      chk("lit_rst_ready", 32'(slot_ready), 32'h1);
      rst_n = 1;
      @(posedge clk); #2;

      // 240-line frame
      vs_pix(); pix(0, 0, 0, 0);
      chk("lit_f0_slot", 32'(cur_slot), 32'h0);
      frame(240, 2);
      vs_pix();
      chk("lit_240", 32'(line_cnt), 32'd240);
      chk("lit_vs_pulse", 32'(pck_vs), 32'h1);
      pix(0, 0, 0, 0);
      chk("lit_vs_drop", 32'(pck_vs), 32'h0);

      // slot 2 requested mid-frame
      frame(10, 2);
      req(3'd2);
      chk("lit_req2_ready", 32'(slot_ready), 32'h0);
      frame(10, 2);
      chk("lit_req2_hold", 32'(cur_slot), 32'h0);
      vs_pix();
      chk("lit_req2_slot", 32'(cur_slot), 32'h2);
      chk("lit_req2_ready1", 32'(slot_ready), 32'h1);
      chk("lit_20", 32'(line_cnt), 32'd20);
      pix(0, 0, 0, 0);

      // out-of-range slot is taken and dropped
      frame(3, 1);
      req(3'd5);
      chk("lit_req5_ready", 32'(slot_ready), 32'h1);
      frame(3, 1);
      vs_pix();
      chk("lit_req5_slot", 32'(cur_slot), 32'h2);
      chk("lit_6", 32'(line_cnt), 32'd6);
      pix(0, 0, 0, 0);

      // request on the vsync edge waits one frame
      frame(2, 2);
      vs_pix(1'b1, 3'd3);
      chk("lit_edge_slot", 32'(cur_slot), 32'h2);
      chk("lit_edge_ready", 32'(slot_ready), 32'h0);
      pix(0, 0, 0, 0);
      frame(2, 2);
      vs_pix();
      chk("lit_edge_commit", 32'(cur_slot), 32'h3);
      chk("lit_edge_ready1", 32'(slot_ready), 32'h1);
      pix(0, 0, 0, 0);

      // one-pixel line, then vsync on the first blank pixel
      pix(0, 0, 1, 0); pix(0, 0, 0, 0);
      pix(1, 24'hABCDEF, 0, 0);
      chk("lit_1px_de", 32'(pck_de), 32'h1);
      chk("lit_1px_rgb", 32'(pck_rgb), 32'hABCDEF);
      pix(0, 0, 0, 0);
      chk("lit_1px_eol_de", 32'(pck_de), 32'h0);
      chk("lit_1px_eol", 32'(pck_rgb), 32'h000003);
      pix(0, 0, 0, 0);
      pix(1, 24'h123456, 0, 0);
      vs_pix();
      chk("lit_vseol_rgb", 32'(pck_rgb), 32'h000003);
      chk("lit_vseol_vs", 32'(pck_vs), 32'h1);
      chk("lit_vseol_lines", 32'(line_cnt), 32'd2);
      pix(0, 0, 0, 0);
      chk("lit_vseol_after", 32'(pck_rgb), 32'h0);

      // saturating line counter
      frame(1100, 1);
      vs_pix();
      chk("lit_1023", 32'(line_cnt), 32'd1023);
      pix(0, 0, 0, 0);

      // reset mid-frame with a request pending
      frame(5, 2);
      req(3'd1);
      chk("lit_req1_ready", 32'(slot_ready), 32'h0);
      rst_n = 0;
      #1;
      chk("lit_mrst_rgb", 32'(pck_rgb), 32'h0);
      chk("lit_mrst_slot", 32'(cur_slot), 32'(DEF_SLOT));
      chk("lit_mrst_lines", 32'(line_cnt), 32'h0);
      chk("lit_mrst_ready", 32'(slot_ready), 32'h1);
      @(posedge clk); #2;
      rst_n = 1;
      @(posedge clk); #2;
      frame(2, 2);
      vs_pix();
      chk("lit_mrst_drop", 32'(cur_slot), 32'(DEF_SLOT));
      chk("lit_mrst_2", 32'(line_cnt), 32'd2);
      pix(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
